// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, bus widths and controller state for the line master.
package axi_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int STRB_W = DATA_W / 8;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_WR   = 3'd3,
      ST_B    = 3'd4
   } state_e;

   // Byte mask covering one whole burst of (len+1) beats of 2^size bytes.
   function automatic logic [ADDR_W-1:0] line_mask(input logic [7:0] len, input logic [2:0] size);
      return ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
   endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 AR/R/AW/W/B channel bundle (no IDs on the response side, single-ID initiator).
interface axi_if;
   import axi_pkg::*;

   logic              arvalid, arready;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic [3:0]        arid;

   logic              rvalid, rready, rlast;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;

   logic              awvalid, awready;
   logic [ADDR_W-1:0] awaddr;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic [3:0]        awid;

   logic              wvalid, wready, wlast;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;

   logic              bvalid, bready;
   logic [1:0]        bresp;

   modport master (
      output arvalid, araddr, arlen, arsize, arburst, arid, input arready,
      input  rvalid, rdata, rresp, rlast, output rready,
      output awvalid, awaddr, awlen, awsize, awburst, awid, input awready,
      output wvalid, wdata, wstrb, wlast, input wready,
      input  bvalid, bresp, output bready
   );

   modport slave (
      input  arvalid, araddr, arlen, arsize, arburst, arid, output arready,
      output rvalid, rdata, rresp, rlast, input rready,
      input  awvalid, awaddr, awlen, awsize, awburst, awid, output awready,
      input  wvalid, wdata, wstrb, wlast, output wready,
      output bvalid, bresp, input bready
   );
endinterface

// File: rtl/axi_master_wr.sv
// Single-beat write sequencing: independent AW/W handshakes, then B captured into a held response.
module axi_master_wr
   import axi_pkg::*;
#(
   parameter logic [2:0] SIZE = 3'd3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              wr_active,
   input  logic              b_active,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   input  logic [STRB_W-1:0] strb,
   output logic              awvalid,
   output logic [ADDR_W-1:0] awaddr,
   output logic [7:0]        awlen,
   output logic [2:0]        awsize,
   output logic [1:0]        awburst,
   output logic [3:0]        awid,
   input  logic              awready,
   output logic              wvalid,
   output logic [DATA_W-1:0] wdata,
   output logic [STRB_W-1:0] wstrb,
   output logic              wlast,
   input  logic              wready,
   input  logic              bvalid,
   input  logic [1:0]        bresp,
   output logic              bready,
   output logic              wr_done,
   output logic              rsp_valid,
   output logic              rsp_err,
   input  logic              rsp_ready,
   output logic              rsp_done
);

   logic aw_done_q, aw_done_d;
   logic w_done_q, w_done_d;
   logic hold_q, hold_d;
   logic err_q, err_d;
   logic aw_hs, w_hs, b_hs;

   assign awvalid = wr_active & ~aw_done_q;
   assign wvalid  = wr_active & ~w_done_q;
   assign awaddr  = addr;
   assign awlen   = 8'd0;
   assign awsize  = SIZE;
   assign awburst = BURST_INCR;
   assign awid    = 4'd0;
   assign wdata   = data;
   assign wstrb   = strb;
   assign wlast   = 1'b1;

   // bready drops while a captured response waits for the consumer.
   assign bready    = b_active & ~hold_q;
   assign rsp_valid = hold_q;
   assign rsp_err   = err_q;

   always_comb begin
      aw_hs    = awvalid & awready;
      w_hs     = wvalid & wready;
      b_hs     = bvalid & bready;
      wr_done  = wr_active & (aw_done_q | aw_hs) & (w_done_q | w_hs);
      rsp_done = hold_q & rsp_ready;
      aw_done_d = wr_done ? 1'b0 : (aw_done_q | aw_hs);
      w_done_d  = wr_done ? 1'b0 : (w_done_q | w_hs);
      hold_d = hold_q;
      err_d  = err_q;
      if (b_hs) begin
         hold_d = 1'b1;
         err_d  = (bresp != RESP_OKAY);
      end else if (rsp_done) begin
         hold_d = 1'b0;
         err_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         hold_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         hold_q    <= hold_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: rtl/axi_line_master.sv
// Cache/LSU single-request port to AXI4 initiator: burst reads passed through, single-beat writes.
// Optional macro AXI_WRAP_BURST_EN: critical-word-first WRAP reads instead of line-aligned INCR.
module axi_line_master
   import axi_pkg::*;
#(
   parameter logic [2:0] SIZE = 3'd3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [7:0]        req_len,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [STRB_W-1:0] req_wstrb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic              rsp_err,
   axi_if.master             out
);

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;

   logic in_r, in_b, r_hs;
   logic wr_done, wr_rsp_valid, wr_rsp_err, wr_rsp_done;

   assign in_r      = (state_q == ST_R);
   assign in_b      = (state_q == ST_B);
   assign r_hs      = out.rvalid & out.rready;
   assign req_ready = (state_q == ST_IDLE);

   assign out.arvalid = (state_q == ST_AR);
   assign out.arlen   = len_q;
   assign out.arsize  = SIZE;
   assign out.arid    = 4'd0;
`ifdef AXI_WRAP_BURST_EN
   assign out.araddr  = addr_q;
   assign out.arburst = (len_q != 8'd0) ? BURST_WRAP : BURST_INCR;
`else
   assign out.araddr  = addr_q & ~line_mask(len_q, SIZE);
   assign out.arburst = BURST_INCR;
`endif

   // Read beats are a same-cycle passthrough; the consumer's ready is the R backpressure.
   assign out.rready = in_r & rsp_ready;
   assign rsp_valid  = in_r ? out.rvalid : (in_b & wr_rsp_valid);
   assign rsp_data   = in_r ? out.rdata : '0;
   assign rsp_last   = in_r ? out.rlast : (in_b & wr_rsp_valid);
   assign rsp_err    = in_r ? ((out.rresp != RESP_OKAY) | (out.rlast != (cnt_q == 8'd0)))
                            : (in_b & wr_rsp_err);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      len_d   = len_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      case (state_q)
         ST_IDLE: if (req_valid) begin
            addr_d  = req_addr;
            len_d   = req_len;
            wdata_d = req_wdata;
            wstrb_d = req_wstrb;
            state_d = req_write ? ST_WR : ST_AR;
         end
         ST_AR: if (out.arready) begin
            cnt_d   = len_q;
            state_d = ST_R;
         end
         ST_R: if (r_hs) begin
            cnt_d = cnt_q - 8'd1;
            if (out.rlast) state_d = ST_IDLE;
         end
         ST_WR: if (wr_done) state_d = ST_B;
         ST_B: if (wr_rsp_done) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request payload only matters once a transaction is under way, so it carries no reset.
   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
   end

   axi_master_wr #(.SIZE(SIZE)) u_wr (
      .clk       (clk),
      .rstn      (rstn),
      .wr_active (state_q == ST_WR),
      .b_active  (in_b),
      .addr      (addr_q),
      .data      (wdata_q),
      .strb      (wstrb_q),
      .awvalid   (out.awvalid),
      .awaddr    (out.awaddr),
      .awlen     (out.awlen),
      .awsize    (out.awsize),
      .awburst   (out.awburst),
      .awid      (out.awid),
      .awready   (out.awready),
      .wvalid    (out.wvalid),
      .wdata     (out.wdata),
      .wstrb     (out.wstrb),
      .wlast     (out.wlast),
      .wready    (out.wready),
      .bvalid    (out.bvalid),
      .bresp     (out.bresp),
      .bready    (out.bready),
      .wr_done   (wr_done),
      .rsp_valid (wr_rsp_valid),
      .rsp_err   (wr_rsp_err),
      .rsp_ready (rsp_ready),
      .rsp_done  (wr_rsp_done)
   );

endmodule

// File: tb/tb_axi_line_master.sv
// Scenario bench for axi_line_master: the bench plays the AXI slave and the response consumer.
module tb_axi_line_master;
   import axi_pkg::*;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr;
   logic [7:0]  req_len;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        rsp_valid, rsp_ready, rsp_last, rsp_err;
   logic [63:0] rsp_data;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   axi_if axi();

   axi_line_master #(.SIZE(3'd3)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_last  (rsp_last),
      .rsp_err   (rsp_err),
      .out       (axi)
   );

   always #5 clk = ~clk;

   task automatic init_inputs();
      req_valid = 0; req_write = 0; req_addr = '0; req_len = '0; req_wdata = '0; req_wstrb = '0;
      rsp_ready = 0;
      axi.arready = 0; axi.awready = 0; axi.wready = 0;
      axi.rvalid = 0; axi.rdata = '0; axi.rresp = RESP_OKAY; axi.rlast = 0;
      axi.bvalid = 0; axi.bresp = RESP_OKAY;
   endtask

   task automatic start_read(input logic [31:0] a, input logic [7:0] l);
      @(negedge clk);
      req_valid = 1; req_write = 0; req_addr = a; req_len = l;
      @(negedge clk);
      req_valid = 0;
      #1;
   endtask

   task automatic start_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
      @(negedge clk);
      req_valid = 1; req_write = 1; req_addr = a; req_wdata = d; req_wstrb = s; req_len = 8'd5;
      @(negedge clk);
      req_valid = 0;
      #1;
   endtask

   task automatic ar_accept();
      axi.arready = 1;
      @(negedge clk);
      axi.arready = 0;
      #1;
   endtask

   // One slave R cycle: present a beat and consumer ready, report what the DUT shows.
   task automatic r_cycle(input logic [63:0] d, input logic last, input logic [1:0] resp, input logic rdy,
                          output logic hs, output logic [63:0] od, output logic ol, output logic oe,
                          output logic ordy);
      @(negedge clk);
      axi.rvalid = 1; axi.rdata = d; axi.rlast = last; axi.rresp = resp; rsp_ready = rdy;
      #1;
      hs = axi.rvalid & axi.rready; od = rsp_data; ol = rsp_last; oe = rsp_err; ordy = axi.rready;
   endtask

   task automatic r_idle();
      @(negedge clk);
      axi.rvalid = 0; axi.rlast = 0; axi.rresp = RESP_OKAY;
      #1;
   endtask

   task automatic test_reset();
      init_inputs();
      rstn = 0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 5'b0) begin
         n_bad++; $display("FAIL reset_axi: got %b expected 00000",
            {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready});
      end
      n_cmp++;
      if ({req_ready, rsp_valid, rsp_last, rsp_err} !== 4'b1000) begin
         n_bad++; $display("FAIL reset_rsp: got %b expected 1000", {req_ready, rsp_valid, rsp_last, rsp_err});
      end
      rstn = 1;
   endtask

   task automatic test_single_read();
      logic hs, ol, oe, ordy;
      logic [63:0] od;
      exp_t e;
      start_read(32'h8000_0010, 8'd0);
      n_cmp++;
      if ({axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arid} !==
          {1'b1, 32'h8000_0010, 8'd0, 3'd3, BURST_INCR, 4'd0}) begin
         n_bad++; $display("FAIL rd1_ar: got v=%b a=%h len=%0d sz=%0d b=%b id=%0d", axi.arvalid, axi.araddr,
            axi.arlen, axi.arsize, axi.arburst, axi.arid);
      end
      ar_accept();
      n_cmp++;
      if (axi.arvalid !== 1'b0) begin n_bad++; $display("FAIL rd1_ar_drop: got %b expected 0", axi.arvalid); end
      sb.push_back('{data: 64'h1122_3344_5566_7788, last: 1'b1, err: 1'b0});
      r_cycle(64'h1122_3344_5566_7788, 1'b1, RESP_OKAY, 1'b1, hs, od, ol, oe, ordy);
      n_cmp++;
      if (hs !== 1'b1 || rsp_valid !== 1'b1) begin
         n_bad++; $display("FAIL rd1_hs: got hs=%b rsp_valid=%b expected 1", hs, rsp_valid);
      end else begin
         e = sb.pop_front();
         n_cmp++;
         if ({od, ol, oe} !== {e.data, e.last, e.err}) begin
            n_bad++; $display("FAIL rd1_beat: got %h/%b/%b expected %h/%b/%b", od, ol, oe, e.data, e.last, e.err);
         end
      end
      r_idle();
      n_cmp++;
      if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rd1_idle: req_ready %b expected 1", req_ready); end
   endtask

   // 4-beat read; rdy_pat gives the consumer ready for the first four R cycles, then held high.
   task automatic test_burst_read(input logic [3:0] rdy_pat, input string tag);
      logic hs, ol, oe, ordy, rdy;
      logic [63:0] od;
      logic [31:0] exp_addr;
      logic [1:0]  exp_burst;
      exp_t e;
      int i = 0;
      int pushed = 0;
`ifdef AXI_WRAP_BURST_EN
      exp_addr = 32'h8000_0018; exp_burst = BURST_WRAP;
`else
      exp_addr = 32'h8000_0000; exp_burst = BURST_INCR;
`endif
      start_read(32'h8000_0018, 8'd3);
      n_cmp++;
      if ({axi.arvalid, axi.araddr, axi.arlen, axi.arburst} !== {1'b1, exp_addr, 8'd3, exp_burst}) begin
         n_bad++; $display("FAIL %s_ar: got v=%b a=%h len=%0d b=%b expected a=%h b=%b", tag, axi.arvalid,
            axi.araddr, axi.arlen, axi.arburst, exp_addr, exp_burst);
      end
      ar_accept();
      for (int c = 0; c < 20 && i < 4; c++) begin
         rdy = (c < 4) ? rdy_pat[3 - c] : 1'b1;
         if (pushed == i) begin
            sb.push_back('{data: 64'hA5A5_0000_0000_0000 | 64'(i), last: (i == 3), err: 1'b0});
            pushed++;
         end
         r_cycle(64'hA5A5_0000_0000_0000 | 64'(i), (i == 3), RESP_OKAY, rdy, hs, od, ol, oe, ordy);
         n_cmp++;
         if (ordy !== rdy) begin n_bad++; $display("FAIL %s_rready c%0d: got %b expected %b", tag, c, ordy, rdy); end
         if (hs) begin
            e = sb.pop_front();
            n_cmp++;
            if ({od, ol, oe} !== {e.data, e.last, e.err}) begin
               n_bad++; $display("FAIL %s_beat%0d: got %h/%b/%b expected %h/%b/%b", tag, i, od, ol, oe,
                  e.data, e.last, e.err);
            end
            i++;
         end
      end
      n_cmp++;
      if (i != 4) begin n_bad++; $display("FAIL %s_count: got %0d beats expected 4", tag, i); end
      r_idle();
      n_cmp++;
      if (req_ready !== 1'b1 || sb.size() != 0) begin
         n_bad++; $display("FAIL %s_end: req_ready %b left %0d expected 1/0", tag, req_ready, sb.size());
      end
      sb.delete();
   endtask

   task automatic test_rlast_err();
      logic hs, ol, oe, ordy;
      logic [63:0] od;
      exp_t e;
      start_read(32'h8000_0200, 8'd3);
      ar_accept();
      for (int i = 0; i < 2; i++) begin
         sb.push_back('{data: 64'(i + 7), last: (i == 1), err: ((i == 1) != (i == 3))});
         r_cycle(64'(i + 7), (i == 1), RESP_OKAY, 1'b1, hs, od, ol, oe, ordy);
         n_cmp++;
         if (hs !== 1'b1) begin
            n_bad++; $display("FAIL rlast_hs%0d: got %b expected 1", i, hs);
         end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({od, ol, oe} !== {e.data, e.last, e.err}) begin
               n_bad++; $display("FAIL rlast_beat%0d: got %h/%b/%b expected %h/%b/%b", i, od, ol, oe,
                  e.data, e.last, e.err);
            end
         end
      end
      r_idle();
      n_cmp++;
      if ({req_ready, axi.rready, rsp_valid} !== 3'b100) begin
         n_bad++; $display("FAIL rlast_idle: got %b expected 100", {req_ready, axi.rready, rsp_valid});
      end
      sb.delete();
   endtask

   task automatic test_write_aw_first();
      exp_t e;
      start_write(32'h8000_0040, 64'h0000_0000_DEAD_BEEF, 8'h0F);
      n_cmp++;
      if ({axi.awvalid, axi.wvalid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awid} !==
          {2'b11, 32'h8000_0040, 8'd0, 3'd3, BURST_INCR, 4'd0}) begin
         n_bad++; $display("FAIL wr_aw: got v=%b%b a=%h len=%0d sz=%0d b=%b", axi.awvalid, axi.wvalid,
            axi.awaddr, axi.awlen, axi.awsize, axi.awburst);
      end
      n_cmp++;
      if ({axi.wdata, axi.wstrb, axi.wlast} !== {64'h0000_0000_DEAD_BEEF, 8'h0F, 1'b1}) begin
         n_bad++; $display("FAIL wr_w: got %h/%h/%b", axi.wdata, axi.wstrb, axi.wlast);
      end
      axi.awready = 1;
      @(negedge clk);
      axi.awready = 0;
      #1;
      n_cmp++;
      if ({axi.awvalid, axi.wvalid} !== 2'b01) begin
         n_bad++; $display("FAIL wr_aw_drop: got %b expected 01", {axi.awvalid, axi.wvalid});
      end
      repeat (2) @(negedge clk);
      axi.wready = 1;
      #1;
      n_cmp++;
      if ({axi.wvalid, axi.bready} !== 2'b10) begin
         n_bad++; $display("FAIL wr_w_hold: got %b expected 10", {axi.wvalid, axi.bready});
      end
      @(negedge clk);
      axi.wready = 0;
      #1;
      n_cmp++;
      if ({axi.wvalid, axi.bready, rsp_valid} !== 3'b010) begin
         n_bad++; $display("FAIL wr_b_wait: got %b expected 010", {axi.wvalid, axi.bready, rsp_valid});
      end
      sb.push_back('{data: 64'd0, last: 1'b1, err: 1'b0});
      axi.bvalid = 1; axi.bresp = RESP_OKAY; rsp_ready = 1;
      @(negedge clk);
      axi.bvalid = 0;
      #1;
      n_cmp++;
      if ({rsp_valid, axi.bready} !== 2'b10) begin
         n_bad++; $display("FAIL wr_rsp: got valid/bready %b expected 10", {rsp_valid, axi.bready});
      end else begin
         e = sb.pop_front();
         n_cmp++;
         if ({rsp_data, rsp_last, rsp_err} !== {e.data, e.last, e.err}) begin
            n_bad++; $display("FAIL wr_rsp_data: got %h/%b/%b expected %h/%b/%b", rsp_data, rsp_last, rsp_err,
               e.data, e.last, e.err);
         end
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({req_ready, rsp_valid} !== 2'b10) begin
         n_bad++; $display("FAIL wr_idle: got %b expected 10", {req_ready, rsp_valid});
      end
      sb.delete();
   endtask

   task automatic test_write_slverr();
      exp_t e;
      start_write(32'h8000_0080, 64'h0123_4567_89AB_CDEF, 8'hFF);
      axi.awready = 1; axi.wready = 1;
      @(negedge clk);
      axi.awready = 0; axi.wready = 0;
      #1;
      n_cmp++;
      if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001) begin
         n_bad++; $display("FAIL slv_b: got %b expected 001", {axi.awvalid, axi.wvalid, axi.bready});
      end
      sb.push_back('{data: 64'd0, last: 1'b1, err: 1'b1});
      axi.bvalid = 1; axi.bresp = RESP_SLVERR; rsp_ready = 0;
      @(negedge clk);
      axi.bvalid = 0; axi.bresp = RESP_OKAY;
      @(negedge clk);
      #1;
      n_cmp++;
      if ({rsp_valid, axi.bready} !== 2'b10) begin
         n_bad++; $display("FAIL slv_hold: got %b expected 10", {rsp_valid, axi.bready});
      end
      rsp_ready = 1;
      #1;
      e = sb.pop_front();
      n_cmp++;
      if ({rsp_data, rsp_last, rsp_err} !== {e.data, e.last, e.err}) begin
         n_bad++; $display("FAIL slv_rsp: got %h/%b/%b expected %h/%b/%b", rsp_data, rsp_last, rsp_err,
            e.data, e.last, e.err);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({req_ready, rsp_valid} !== 2'b10) begin
         n_bad++; $display("FAIL slv_idle: got %b expected 10", {req_ready, rsp_valid});
      end
      sb.delete();
   endtask

   task automatic test_reset_mid_r();
      logic hs, ol, oe, ordy;
      logic [63:0] od;
      start_read(32'h8000_0100, 8'd3);
      ar_accept();
      r_cycle(64'h55, 1'b0, RESP_OKAY, 1'b1, hs, od, ol, oe, ordy);
      n_cmp++;
      if (hs !== 1'b1 || od !== 64'h55) begin
         n_bad++; $display("FAIL rst_beat1: got hs=%b data=%h expected 1/55", hs, od);
      end
      @(negedge clk);
      axi.rdata = 64'h66;
      rstn = 0;
      @(negedge clk);
      #1;
      n_cmp++;
      if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, rsp_valid, req_ready} !== 7'b0000001) begin
         n_bad++; $display("FAIL rst_mid: got %b expected 0000001",
            {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, rsp_valid, req_ready});
      end
      axi.rvalid = 0; axi.rlast = 0;
      rstn = 1;
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_read();
      test_burst_read(4'b1111, "burst");
      test_burst_read(4'b1001, "bp");
      test_write_aw_first();
      test_write_slverr();
      test_rlast_err();
      test_reset_mid_r();
      test_single_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axi_line_master.md
# axi_line_master

AXI4 initiator that turns single-request cache/LSU traffic into AXI transactions on a 64-bit `axi_if`. It sits between the core's memory-side request port and the memory interconnect or RAM model. Reads may be bursts (cache-line refill, up to 16 beats) and are returned beat-by-beat. Writes are single-beat, with byte strobes, and are acknowledged after the B response.

## Interface

**Parameters**
- `SIZE`, default 3'd3: `arsize`/`awsize` value (bytes per beat = 2^SIZE).

**Ports**
- `clk`  in  1  clock.
- `rstn`  in  1  reset: synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address.
- `req_len`  in  8  read beats−1; legal values 0, 1, 3, 7, 15; ignored for writes.
- `req_wdata`  in  64  write data.
- `req_wstrb`  in  8  write byte strobes.
- `rsp_valid`  out  1  response beat valid.
- `rsp_ready`  in  1  consumer accepts the beat.
- `rsp_data`  out  64  read data; 0 for write acknowledgements.
- `rsp_last`  out  1  final beat of the transaction.
- `rsp_err`  out  1  nonzero resp, or rlast/beat-count mismatch.
- `out`  `axi_if.master`  AXI4 AR/R/AW/W/B channels.

## Operation

**States:** IDLE, AR, R, WR (AW and W outstanding), B.

- **IDLE**
  - `req_ready=1`.
  - On accept, latch addr/len/wdata/wstrb/write.
  - read → AR.
  - write → WR.
- **AR**
  - `arvalid=1`; `araddr` (see Configuration), `arlen=len`, `arsize=SIZE`.
  - On `arvalid & arready`: drop `arvalid`, load `cnt=len`, go to R.
- **R**
  - `rready = rsp_ready`.
  - Combinational passthrough: `rsp_valid=rvalid`, `rsp_data=rdata`, `rsp_last=rlast`.
  - `rsp_err = (rresp!=0) | (rlast != (cnt==0))`.
  - On each R handshake: `cnt` decrements.
  - On a handshake with `rlast`: go to IDLE.
- **WR**
  - `awvalid=1` and `wvalid=1`, both asserted in the same cycle.
  - `awaddr=addr`, `awlen=0`, `awsize=SIZE`, `awburst=INCR`.
  - `wdata`, `wstrb`, `wlast=1`.
  - Each valid drops independently on its own handshake; `aw_done`/`w_done` flags record completion.
  - Both done → B.
- **B**
  - `bready=1`.
  - On B handshake, present one response: `rsp_valid=1`, `rsp_last=1`, `rsp_data=0`, `rsp_err=(bresp!=0)`.
  - Hold the response until `rsp_ready`, then go to IDLE.

**Other rules**
- `arid`/`awid` = 0.
- Non-listed `req_len` values: behaviour undefined; the verification bench never drives them.

## Timing

- **Reset values:** state=IDLE, `req_ready=1`, all AXI valids=0, `rready=0`, `bready=0`, `rsp_valid=0`, `rsp_last=0`, `rsp_err=0`, `cnt=0`, `aw_done=0`, `w_done=0`.
- **Accept to address:** accept in cycle N → `arvalid` or `awvalid`/`wvalid` high in cycle N+1 (registered outputs).
- **Read latency:** no added latency beyond the slave's; R beats pass through in the same cycle.
- **Backpressure:** `rsp_ready=0` stalls R via `rready`; no data is dropped.
- **Write ack:** `rsp_valid` is registered, rising the cycle after the B handshake. `bready` is low while the response is held.
- **Next request:** `req_ready` returns high the cycle after the final response handshake. No outstanding overlap; one transaction at a time.
- **AXI compliance:** valids stay asserted until their handshake.
- **AW/W ordering:** AW and W may handshake in the same or different cycles, in either order.
- **Reset mid-transaction:** all state clears the next edge. The transaction is abandoned; the slave is reset in the same domain.

## Configuration

`AXI_WRAP_BURST_EN`
- **Defined:** reads with `len>0` use `arburst=WRAP` and `araddr=req_addr` unmodified (critical-word-first). `len==0` uses INCR.
- **Undefined:** all reads use `arburst=INCR` and `araddr = req_addr & ~(((len+1)<<SIZE)−1)` (line-aligned, first beat = lowest address).
- Write behaviour is identical either way.

## Structure

- **Package `axi_pkg`:**
  - burst codes (FIXED=2'b00, INCR=2'b01, WRAP=2'b10);
  - resp codes (OKAY=2'b00, SLVERR=2'b10);
  - state enum (IDLE, AR, R, WR, B).
- **Sub-module `axi_master_wr`:** handles the AW/W/done-flag/B sequencing; the top module owns arbitration and the R path.

## Test plan

- **Single read:** read, addr 0x8000_0010, len 0, slave returns 0x1122334455667788 OKAY → `arlen=0`, one beat, `rsp_last=1`, `rsp_err=0`.
- **4-beat read:** read, addr 0x8000_0018, len 3.
  - With macro: WRAP, `araddr` 0x8000_0018; beat addresses 0x18, 0x00, 0x08, 0x10.
  - Without macro: INCR, `araddr` 0x8000_0000.
  - Both: 4 beats, `rsp_last` on beat 4 only.
- **Write, AW before W:** write, wstrb 0x0F, data 0xDEADBEEF; slave takes AW 3 cycles before W → one `rsp_valid` after B, `rsp_data=0`, `rsp_err=0`.
- **Backpressure:** `rsp_ready` toggled 1,0,0,1 during a 4-beat read → `rready` mirrors it; all 4 beats arrive in order, none lost.
- **Errors:**
  - bresp=SLVERR → `rsp_err=1`.
  - R stream with rlast on beat 2 of len 3 → `rsp_err=1` on that beat, return to IDLE.
- **Reset mid-R:** `rstn=0` after beat 1 of 4 → next edge: all valids 0, `req_ready=1`.
